mem_wb_reg: RTL and testbench

- MEM/WB pipeline register of the RV32I 5-stage pipelined CPU.
- Captures every memory-stage result and writeback control field on each rising clock edge.
- Presents the captured values to the writeback stage for one full cycle.
- Pure storage: no decode, muxing or arithmetic; the writeback mux downstream selects among the captured values.

---
 rtl/mem_wb_reg_pkg.sv | 32 +++
 rtl/mem_wb_reg_pipe_field_reg.sv | 20 ++
 rtl/mem_wb_reg.sv | 97 +++++++++
 tb/tb_mem_wb_reg.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mem_wb_reg_pkg.sv
// Shared widths and encodings for the MEM/WB pipeline register and the
// writeback stage that consumes its outputs.
package mem_wb_reg_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned SEL_W  = 3;

    // Writeback source select carried in sel_MemToReg
    typedef enum logic [SEL_W-1:0] {
        SEL_ALU    = 3'b000,
        SEL_MEM    = 3'b001,
        SEL_PC4    = 3'b010,
        SEL_IMM    = 3'b011,
        SEL_BRANCH = 3'b100
    } mem_to_reg_e;

    // RV32I load funct3 values; WB uses them for size and sign handling
    typedef enum logic [SEL_W-1:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct_e;

    // Unsigned loads zero-extend; all other load encodings sign-extend.
    function automatic logic load_is_unsigned(input logic [SEL_W-1:0] funct);
        return funct[2];
    endfunction

endpackage

// File: rtl/mem_wb_reg_pipe_field_reg.sv
// One pipeline field: WIDTH-bit D-register with asynchronous active-low
// clear to zero.
module pipe_field_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: every memory-stage result and writeback control
// field is captured unconditionally on each rising edge, cleared by reset.
module mem_wb_reg
    import mem_wb_reg_pkg::*;
#(
    parameter int unsigned XLEN   = mem_wb_reg_pkg::XLEN,
    parameter int unsigned REG_AW = mem_wb_reg_pkg::REG_AW,
    parameter int unsigned SEL_W  = mem_wb_reg_pkg::SEL_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [XLEN-1:0]   MEM_PCplus4,
    input  logic [XLEN-1:0]   MEM_BranchAddr,
    input  logic [XLEN-1:0]   MEM_immediate,
    input  logic              MEM_cntl_RegWrite,
    input  logic [SEL_W-1:0]  MEM_sel_MemToReg,
    input  logic [SEL_W-1:0]  MEM_funct,
    input  logic [XLEN-1:0]   MEM_ReadMemData,
    input  logic [XLEN-1:0]   MEM_ALUResult,
    input  logic [REG_AW-1:0] MEM_WriteRegNum,
    output logic [XLEN-1:0]   WB_PCplus4,
    output logic [XLEN-1:0]   WB_BranchAddr,
    output logic [XLEN-1:0]   WB_immediate,
    output logic              WB_cntl_RegWrite,
    output logic [SEL_W-1:0]  WB_sel_MemToReg,
    output logic [SEL_W-1:0]  WB_funct,
    output logic [XLEN-1:0]   WB_ReadMemData,
    output logic [XLEN-1:0]   WB_ALUResult,
    output logic [REG_AW-1:0] WB_WriteRegNum
);

    pipe_field_reg #(.WIDTH(XLEN)) u_pcplus4 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (MEM_PCplus4),
        .q       (WB_PCplus4)
    );

    pipe_field_reg #(.WIDTH(XLEN)) u_branch_addr (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (MEM_BranchAddr),
        .q       (WB_BranchAddr)
    );

    pipe_field_reg #(.WIDTH(XLEN)) u_immediate (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (MEM_immediate),
        .q       (WB_immediate)
    );

    // Clearing RegWrite on reset keeps the register file untouched until the
    // first real instruction reaches writeback.
    pipe_field_reg #(.WIDTH(1)) u_reg_write (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (MEM_cntl_RegWrite),
        .q       (WB_cntl_RegWrite)
    );

    pipe_field_reg #(.WIDTH(SEL_W)) u_mem_to_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (MEM_sel_MemToReg),
        .q       (WB_sel_MemToReg)
    );

    pipe_field_reg #(.WIDTH(SEL_W)) u_funct (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (MEM_funct),
        .q       (WB_funct)
    );

    pipe_field_reg #(.WIDTH(XLEN)) u_read_mem_data (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (MEM_ReadMemData),
        .q       (WB_ReadMemData)
    );

    pipe_field_reg #(.WIDTH(XLEN)) u_alu_result (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (MEM_ALUResult),
        .q       (WB_ALUResult)
    );

    pipe_field_reg #(.WIDTH(REG_AW)) u_write_reg_num (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (MEM_WriteRegNum),
        .q       (WB_WriteRegNum)
    );

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed bench for mem_wb_reg: reset, capture, async reset, recapture,
// hold between edges and back-to-back streaming.
module tb_mem_wb_reg;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] br;
        logic [31:0] imm;
        logic        rw;
        logic [2:0]  sel;
        logic [2:0]  fn;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] MEM_PCplus4, MEM_BranchAddr, MEM_immediate;
    logic        MEM_cntl_RegWrite;
    logic [2:0]  MEM_sel_MemToReg, MEM_funct;
    logic [31:0] MEM_ReadMemData, MEM_ALUResult;
    logic [4:0]  MEM_WriteRegNum;
    logic [31:0] WB_PCplus4, WB_BranchAddr, WB_immediate;
    logic        WB_cntl_RegWrite;
    logic [2:0]  WB_sel_MemToReg, WB_funct;
    logic [31:0] WB_ReadMemData, WB_ALUResult;
    logic [4:0]  WB_WriteRegNum;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_wb_reg #(.XLEN(32), .REG_AW(5), .SEL_W(3)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .MEM_PCplus4       (MEM_PCplus4),
        .MEM_BranchAddr    (MEM_BranchAddr),
        .MEM_immediate     (MEM_immediate),
        .MEM_cntl_RegWrite (MEM_cntl_RegWrite),
        .MEM_sel_MemToReg  (MEM_sel_MemToReg),
        .MEM_funct         (MEM_funct),
        .MEM_ReadMemData   (MEM_ReadMemData),
        .MEM_ALUResult     (MEM_ALUResult),
        .MEM_WriteRegNum   (MEM_WriteRegNum),
        .WB_PCplus4        (WB_PCplus4),
        .WB_BranchAddr     (WB_BranchAddr),
        .WB_immediate      (WB_immediate),
        .WB_cntl_RegWrite  (WB_cntl_RegWrite),
        .WB_sel_MemToReg   (WB_sel_MemToReg),
        .WB_funct          (WB_funct),
        .WB_ReadMemData    (WB_ReadMemData),
        .WB_ALUResult      (WB_ALUResult),
        .WB_WriteRegNum    (WB_WriteRegNum)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] pc4, br, imm, input logic rw,
                                input logic [2:0] sel, fn, input logic [31:0] rd, alu,
                                input logic [4:0] wr);
        vec_t v;
        v.pc4 = pc4; v.br = br; v.imm = imm; v.rw = rw; v.sel = sel;
        v.fn = fn; v.rd = rd; v.alu = alu; v.wr = wr;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        MEM_PCplus4       = v.pc4;
        MEM_BranchAddr    = v.br;
        MEM_immediate     = v.imm;
        MEM_cntl_RegWrite = v.rw;
        MEM_sel_MemToReg  = v.sel;
        MEM_funct         = v.fn;
        MEM_ReadMemData   = v.rd;
        MEM_ALUResult     = v.alu;
        MEM_WriteRegNum   = v.wr;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check_val({tag, ".pc4"}, WB_PCplus4,              v.pc4);
        check_val({tag, ".br"},  WB_BranchAddr,           v.br);
        check_val({tag, ".imm"}, WB_immediate,            v.imm);
        check_val({tag, ".rw"},  {31'd0, WB_cntl_RegWrite}, {31'd0, v.rw});
        check_val({tag, ".sel"}, {29'd0, WB_sel_MemToReg},  {29'd0, v.sel});
        check_val({tag, ".fn"},  {29'd0, WB_funct},         {29'd0, v.fn});
        check_val({tag, ".rd"},  WB_ReadMemData,          v.rd);
        check_val({tag, ".alu"}, WB_ALUResult,            v.alu);
        check_val({tag, ".wr"},  {27'd0, WB_WriteRegNum},   {27'd0, v.wr});
    endtask

    vec_t zero_v, va, vb, vc, vd;
    vec_t b2b [4];

    initial begin
        zero_v = mk('0, '0, '0, 1'b0, 3'b000, 3'b000, '0, '0, 5'd0);
        va = mk(32'h100, 32'h200, 32'h300, 1'b1, 3'b001, 3'b010, 32'hABCD1234, 32'h56789ABC, 5'd1);
        vb = mk(32'h400, 32'h500, 32'h600, 1'b1, 3'b010, 3'b011, 32'hDEF01234, 32'hFEDCBA98, 5'd2);
        vc = mk(32'h0000_1004, 32'h0000_2000, 32'h1234_5000, 1'b0, 3'b011, 3'b100, 32'h0F0F0F0F, 32'hF0F0F0F0, 5'd17);
        vd = mk(32'h8000_0000, 32'h7FFF_FFFC, 32'hFFFF_F800, 1'b1, 3'b100, 3'b101, 32'h8000_0001, 32'h0000_0080, 5'd30);
        b2b[0] = mk('1, '1, '1, 1'b1, 3'b111, 3'b111, '1, '1, 5'd31);
        b2b[1] = mk(32'h0000_0004, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 3'b000, 3'b000, 32'h0000_00FF, 32'hFFFF_FF00, 5'd0);
        b2b[2] = mk(32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 3'b111, 3'b001, 32'hFFFF_0000, 32'h0000_FFFF, 5'd31);
        b2b[3] = mk(32'h1357_9BDF, 32'h2468_ACE0, 32'hCAFE_BABE, 1'b1, 3'b101, 3'b110, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd15);

        // Reset with all inputs zero
        reset_n = 1'b0;
        drive(zero_v);
        #10;
        check_all("reset", zero_v);

        // Release reset between edges; capture lands on the following edge
        @(negedge clk);
        reset_n = 1'b1;
        drive(va);
        #1 check_all("pre_cap", zero_v);
        @(posedge clk);
        #1 check_all("cap", va);

        // Async reset mid-cycle clears without a clock edge, and stays clear
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_all("async_rst", zero_v);
        drive(vb);
        repeat (2) @(posedge clk);
        #1 check_all("rst_hold", zero_v);

        // Recapture after release
        @(negedge clk);
        reset_n = 1'b1;
        #1 check_all("pre_recap", zero_v);
        @(posedge clk);
        #1 check_all("recap", vb);

        // Input changes between edges must not reach outputs early
        @(negedge clk);
        drive(vc);
        #1 check_all("hold_b", vb);
        @(posedge clk);
        #2 drive(vd);
        #1 check_all("hold_c", vc);
        @(posedge clk);
        #1 check_all("lat_d", vd);

        // Back-to-back: one new vector per cycle, each one cycle delayed
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(b2b[i]);
            @(posedge clk);
            #1 check_all($sformatf("b2b%0d", i), b2b[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
